// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SPI-mode SD command engine. Takes a command from the card
// controller, sends the six-byte packet through the byte-level SPI master,
// polls for the response within the NCR window, captures up to MAX_RESP_BYTES
// response bytes and, for R1b commands, waits for the card to stop signalling busy.
// Build option: define SD_CMD_CRC7_EN to compute CRC7 in hardware. Without it,
// the CRC byte comes from a small table (CMD0 / CMD8 values, 0x01 otherwise).
//
// state | meaning
// IDLE  | cmd_ready=1, waiting for a command
// SEND  | sending the 6-byte command packet
// POLL  | clocking 0xFF until the card answers (NCR window)
// RESP  | capturing the remaining response bytes
// BUSY  | R1b: clocking 0xFF until the card returns a non-zero byte
// DONE  | one-cycle completion pulse

module sd_cmd_engine #(
   parameter int SPI_SIZE       = 8,
   parameter int MAX_RESP_BYTES = 5,
   parameter int RESP_LEN_BITS  = 3,
   parameter int NCR_MAX        = 8,
   parameter int BUSY_MAX       = 65535,
   parameter int BUSY_CNT_BITS  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [5:0]                  cmd_index,
   input  logic [31:0]                 cmd_arg,
   input  logic [RESP_LEN_BITS-1:0]    cmd_resp_len,
   input  logic                        cmd_busy,
   output logic                        resp_valid,
   output logic                        resp_timeout,
   output logic [8*MAX_RESP_BYTES-1:0] resp_bytes,
   input  logic                        spi_ready,
   output logic                        spi_req,
   output logic                        spi_tx_en,
   output logic [SPI_SIZE-1:0]         spi_tx_data,
   input  logic [SPI_SIZE-1:0]         spi_rx_data
);
   localparam int NCR_BITS = $clog2(NCR_MAX + 1);
   localparam int BCW      = (RESP_LEN_BITS > 3) ? RESP_LEN_BITS : 3;

   typedef enum logic [2:0] {IDLE, SEND, POLL, RESP, BUSY, DONE} state_t;
   state_t state, state_nx;

   logic [5:0]               index_q;
   logic [31:0]              arg_q;
   logic [RESP_LEN_BITS-1:0] len_q;
   logic [RESP_LEN_BITS-1:0] len_clamped;
   logic                     busy_q;
   logic [BCW-1:0]           byte_cnt;
   logic [NCR_BITS-1:0]      ncr_cnt;
   logic [BUSY_CNT_BITS-1:0] busy_cnt;
   logic                     xfer_act;
   logic                     ready_dropped;
   logic                     xfer_done;
   logic                     accept;
   logic [7:0]               pkt_byte;
   logic [7:0]               crc_byte;

   assign accept    = cmd_valid && cmd_ready;
   // A byte is finished the first cycle spi_ready is back high after it dropped.
   assign xfer_done = xfer_act && ready_dropped && spi_ready;

   // Length 0 means a plain R1; anything longer than the buffer is clamped.
   always_comb begin
      if (cmd_resp_len == '0)
         len_clamped = RESP_LEN_BITS'(1);
      else if (cmd_resp_len > RESP_LEN_BITS'(MAX_RESP_BYTES))
         len_clamped = RESP_LEN_BITS'(MAX_RESP_BYTES);
      else
         len_clamped = cmd_resp_len;
   end

   // Packet byte selected by the send position.
   always_comb begin
      case (byte_cnt)
         BCW'(0): pkt_byte = {2'b01, index_q};
         BCW'(1): pkt_byte = arg_q[31:24];
         BCW'(2): pkt_byte = arg_q[23:16];
         BCW'(3): pkt_byte = arg_q[15:8];
         BCW'(4): pkt_byte = arg_q[7:0];
         default: pkt_byte = crc_byte;
      endcase
   end

`ifdef SD_CMD_CRC7_EN
   logic [6:0] crc_q;

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic [7:0] data);
      logic [6:0] c;
      logic       fb;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         fb = c[6] ^ data[i];
         c  = {c[5:0], 1'b0};
         if (fb)
            c = c ^ 7'h09;
      end
      return c;
   endfunction

   // Fold each of packet bytes 0-4 into the CRC as it completes; byte 5 follows later.
   always_ff @(posedge clk) begin
      if (rst)
         crc_q <= '0;
      else if (accept)
         crc_q <= '0;
      else if (state == SEND && xfer_done && byte_cnt != BCW'(5))
         crc_q <= crc7_step(crc_q, pkt_byte);
   end

   assign crc_byte = {crc_q, 1'b1};
`else
   // SPI mode ignores CRC except for CMD0 and CMD8, which are sent with fixed args.
   always_comb begin
      case (index_q)
         6'd0:    crc_byte = 8'h95;
         6'd8:    crc_byte = 8'h87;
         default: crc_byte = 8'h01;
      endcase
   end
`endif

   // Track the byte in flight so only one request is issued per byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_act      <= 1'b0;
         ready_dropped <= 1'b0;
      end else if (spi_req) begin
         xfer_act      <= 1'b1;
         ready_dropped <= 1'b0;
      end else if (xfer_done) begin
         xfer_act      <= 1'b0;
      end else if (xfer_act && !spi_ready) begin
         ready_dropped <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state and handshake/SPI outputs.
   always_comb begin
      state_nx    = state;
      cmd_ready   = 1'b0;
      resp_valid  = 1'b0;
      spi_req     = 1'b0;
      spi_tx_en   = 1'b0;
      spi_tx_data = 8'hFF;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid)
               state_nx = SEND;
         end
         SEND: begin
            spi_tx_en   = 1'b1;
            spi_tx_data = pkt_byte;
            spi_req     = !xfer_act && spi_ready;
            if (xfer_done && byte_cnt == BCW'(5))
               state_nx = POLL;
         end
         POLL: begin
            spi_req = !xfer_act && spi_ready;
            if (xfer_done) begin
               if (spi_rx_data != 8'hFF) begin
                  if (len_q != RESP_LEN_BITS'(1))
                     state_nx = RESP;
                  else if (busy_q)
                     state_nx = BUSY;
                  else
                     state_nx = DONE;
               end else if (ncr_cnt <= NCR_BITS'(1)) begin
                  state_nx = DONE;
               end
            end
         end
         RESP: begin
            spi_req = !xfer_act && spi_ready;
            if (xfer_done && byte_cnt == BCW'(len_q) - BCW'(1))
               state_nx = busy_q ? BUSY : DONE;
         end
         BUSY: begin
            spi_req = !xfer_act && spi_ready;
            if (xfer_done && (spi_rx_data != 8'h00 || busy_cnt <= BUSY_CNT_BITS'(1)))
               state_nx = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Command latch, byte position, NCR/busy down-counters and response capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         index_q      <= '0;
         arg_q        <= '0;
         len_q        <= '0;
         busy_q       <= 1'b0;
         byte_cnt     <= '0;
         ncr_cnt      <= '0;
         busy_cnt     <= '0;
         resp_timeout <= 1'b0;
         resp_bytes   <= '0;
      end else if (accept) begin
         index_q      <= cmd_index;
         arg_q        <= cmd_arg;
         len_q        <= len_clamped;
         busy_q       <= cmd_busy;
         byte_cnt     <= '0;
         ncr_cnt      <= NCR_BITS'(NCR_MAX);
         busy_cnt     <= BUSY_CNT_BITS'(BUSY_MAX);
         resp_timeout <= 1'b0;
         resp_bytes   <= '0;
      end else if (xfer_done) begin
         case (state)
            SEND: byte_cnt <= (byte_cnt == BCW'(5)) ? '0 : byte_cnt + BCW'(1);
            POLL: begin
               if (spi_rx_data != 8'hFF) begin
                  resp_bytes[7:0] <= spi_rx_data;
                  byte_cnt        <= BCW'(1);
               end else begin
                  if (ncr_cnt <= NCR_BITS'(1))
                     resp_timeout <= 1'b1;
                  if (ncr_cnt != '0)
                     ncr_cnt <= ncr_cnt - NCR_BITS'(1);
               end
            end
            RESP: begin
               resp_bytes[8*byte_cnt +: 8] <= spi_rx_data;
               byte_cnt                    <= byte_cnt + BCW'(1);
            end
            BUSY: begin
               if (spi_rx_data == 8'h00) begin
                  if (busy_cnt <= BUSY_CNT_BITS'(1))
                     resp_timeout <= 1'b1;
                  if (busy_cnt != '0)
                     busy_cnt <= busy_cnt - BUSY_CNT_BITS'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb_sd_cmd_engine: randomized and directed bench for sd_cmd_engine with a
// behavioural SPI card and a stream-scanning reference model.

module tb_sd_cmd_engine;
   localparam int MAXB = 5;
   localparam int NCR  = 8;
   localparam int BMAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic [2:0]  cmd_resp_len;
   logic        cmd_busy;
   logic        resp_valid;
   logic        resp_timeout;
   logic [39:0] resp_bytes;
   logic        spi_ready;
   logic        spi_req;
   logic        spi_tx_en;
   logic [7:0]  spi_tx_data;
   logic [7:0]  spi_rx_data;

   sd_cmd_engine #(
      .SPI_SIZE(8), .MAX_RESP_BYTES(MAXB), .RESP_LEN_BITS(3),
      .NCR_MAX(NCR), .BUSY_MAX(BMAX), .BUSY_CNT_BITS(16)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
      .cmd_arg(cmd_arg), .cmd_resp_len(cmd_resp_len), .cmd_busy(cmd_busy),
      .resp_valid(resp_valid), .resp_timeout(resp_timeout), .resp_bytes(resp_bytes),
      .spi_ready(spi_ready), .spi_req(spi_req), .spi_tx_en(spi_tx_en),
      .spi_tx_data(spi_tx_data), .spi_rx_data(spi_rx_data)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- SPI master / card model ----------------
   logic [7:0] card_q[$];
   logic [7:0] tx_log[$];
   logic [7:0] stim_q[$];
   int         req_mon = 0;
   int         bad_req = 0;
   int         ph = 0;
   int         wait_cnt = 0;
   logic       cur_en = 1'b0;

   initial begin
      spi_ready   = 1'b1;
      spi_rx_data = 8'hFF;
      forever begin
         @(negedge clk);
         if (spi_req) begin
            req_mon++;
            tx_log.push_back(spi_tx_en ? spi_tx_data : 8'hFF);
            if (!spi_ready || ph != 0)
               bad_req++;
         end
         case (ph)
            0: if (spi_req) begin
                  cur_en   = spi_tx_en;
                  wait_cnt = $urandom_range(0, 2);
                  ph       = 1;
               end
            1: if (wait_cnt == 0) begin
                  spi_ready = 1'b0;
                  wait_cnt  = $urandom_range(0, 2);
                  ph        = 2;
               end else wait_cnt--;
            default: if (wait_cnt == 0) begin
                  if (!cur_en && card_q.size() > 0)
                     spi_rx_data = card_q.pop_front();
                  else
                     spi_rx_data = 8'hFF;
                  spi_ready = 1'b1;
                  ph        = 0;
               end else wait_cnt--;
         endcase
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] byte_at(input logic [7:0] s[$], input int p);
      return (p < s.size()) ? s[p] : 8'hFF;
   endfunction

   function automatic logic [7:0] exp_crc(input logic [5:0] idx, input logic [31:0] arg);
`ifdef SD_CMD_CRC7_EN
      logic [46:0] r;
      r = {2'b01, idx, arg, 7'b0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return {r[6:0], 1'b1};
`else
      if (idx == 6'd0) return 8'h95;
      if (idx == 6'd8) return 8'h87;
      return 8'h01;
`endif
   endfunction

   // Walk the card's byte stream the way the protocol reads it.
   task automatic ref_model(input logic [7:0] s[$], input int len_in, input bit busy,
                            output logic [39:0] resp, output bit to, output int xfers);
      int p, L, ff, z;
      L     = (len_in == 0) ? 1 : ((len_in > MAXB) ? MAXB : len_in);
      resp  = '0;
      to    = 1'b0;
      p     = 0;
      ff    = 0;
      xfers = 0;
      while (byte_at(s, p) == 8'hFF && ff < NCR) begin ff++; p++; end
      if (ff == NCR) begin
         to    = 1'b1;
         xfers = NCR;
         return;
      end
      for (int i = 0; i < L; i++) begin
         resp[8*i +: 8] = byte_at(s, p);
         p++;
      end
      if (busy) begin
         z = 0;
         while (byte_at(s, p) == 8'h00 && z < BMAX) begin z++; p++; end
         if (z == BMAX) to = 1'b1;
         else p++;
      end
      xfers = p;
   endtask

   logic [7:0] last_crc;
   int         last_reqs;

   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [2:0] len, input logic busy);
      logic [39:0] e_resp;
      bit          e_to;
      int          e_x, base_req, base_tx, cyc, extra, non_ff;
      logic [47:0] got_pkt, exp_pkt;
      ref_model(stim_q, int'(len), busy, e_resp, e_to, e_x);
      card_q   = stim_q;
      base_req = req_mon;
      base_tx  = tx_log.size();
      cyc = 0;
      while (!cmd_ready && cyc < 200) begin @(negedge clk); cyc++; end
      check_val("ready_before", cmd_ready, 1);
      cmd_index    = idx;
      cmd_arg      = arg;
      cmd_resp_len = len;
      cmd_busy     = busy;
      cmd_valid    = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      check_val("accepted", cmd_ready, 0);
      check_val("clear_bytes", resp_bytes, 0);
      cyc = 0;
      while (!resp_valid && cyc < 3000) begin @(negedge clk); cyc++; end
      if (!resp_valid) begin
         check_val("done_wait", resp_valid, 1);
         return;
      end
      check_val("timeout", resp_timeout, e_to);
      check_val("resp", resp_bytes, e_resp);
      exp_pkt = {2'b01, idx, arg, exp_crc(idx, arg)};
      got_pkt = '0;
      non_ff  = 0;
      for (int i = 0; i < tx_log.size() - base_tx; i++) begin
         if (i < 6) got_pkt[47-8*i -: 8] = tx_log[base_tx+i];
         else if (tx_log[base_tx+i] != 8'hFF) non_ff++;
      end
      check_val("packet", got_pkt, exp_pkt);
      check_val("rx_phase_tx", non_ff, 0);
      last_crc = got_pkt[7:0];
      @(negedge clk);
      check_val("ready_after", cmd_ready, 1);
      extra = resp_valid ? 1 : 0;
      repeat (3) begin @(negedge clk); if (resp_valid) extra++; end
      check_val("pulse", extra, 0);
      check_val("hold", resp_bytes, e_resp);
      last_reqs = req_mon - base_req;
      check_val("reqs", last_reqs, 6 + e_x);
   endtask

   int cyc, pulses, base_req, nff, nz;

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0;
      cmd_resp_len = '0; cmd_busy = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_ready", cmd_ready, 1);
      check_val("rst_valid", resp_valid, 0);
      check_val("rst_timeout", resp_timeout, 0);
      check_val("rst_bytes", resp_bytes, 0);
      check_val("rst_req", spi_req, 0);
      check_val("rst_tx_en", spi_tx_en, 0);
      check_val("rst_tx_data", spi_tx_data, 8'hFF);
      rst = 1'b0;
      @(negedge clk);

      // CMD0
      stim_q = {8'hFF, 8'hFF, 8'h01};
      run_cmd(6'd0, 32'h0, 3'd1, 1'b0);
      check_val("cmd0_crc", last_crc, 8'h95);
      check_val("cmd0_reqs", last_reqs, 9);
      check_val("cmd0_r1", resp_bytes, 40'h01);

      // CMD8
      stim_q = {8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
      run_cmd(6'd8, 32'h0000_01AA, 3'd5, 1'b0);
      check_val("cmd8_crc", last_crc, 8'h87);
      check_val("cmd8_r7", resp_bytes, 40'hAA01000001);

      // CMD58, card silent: NCR timeout
      stim_q = {};
      run_cmd(6'd58, 32'h0, 3'd5, 1'b0);
      check_val("ncr_to", resp_timeout, 1);
      check_val("ncr_reqs", last_reqs, 6 + NCR);

      // CMD12 R1b: release after 3 busy bytes, then limit hit at BMAX zeros
      stim_q = {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
      run_cmd(6'd12, 32'h0, 3'd1, 1'b1);
      check_val("busy_ok_to", resp_timeout, 0);
      check_val("busy_ok_reqs", last_reqs, 11);
      stim_q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_cmd(6'd12, 32'h0, 3'd1, 1'b1);
      check_val("busy_lim_to", resp_timeout, 1);
      check_val("busy_lim_reqs", last_reqs, 6 + 1 + BMAX);

      // Reset during SEND byte 3
      stim_q = {8'h00};
      card_q = stim_q;
      base_req = req_mon;
      cmd_index = 6'd17; cmd_arg = 32'h1234; cmd_resp_len = 3'd1; cmd_busy = 1'b0;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc = 0;
      while (req_mon - base_req < 4 && cyc < 500) begin @(negedge clk); cyc++; end
      check_val("rst_mid_reach", req_mon - base_req, 4);
      rst = 1'b1;
      @(negedge clk);
      check_val("rst_mid_req", spi_req, 0);
      check_val("rst_mid_ready", cmd_ready, 1);
      check_val("rst_mid_valid", resp_valid, 0);
      rst = 1'b0;
      base_req = req_mon;
      pulses = 0;
      repeat (20) begin @(negedge clk); if (resp_valid) pulses++; end
      check_val("rst_mid_pulses", pulses, 0);
      check_val("rst_mid_idle_reqs", req_mon - base_req, 0);
      stim_q = {8'hFF, 8'h01};
      run_cmd(6'd0, 32'h0, 3'd1, 1'b0);
      check_val("post_rst_r1", resp_bytes, 40'h01);

      // cmd_valid held high: len 0 then len 7, re-accepted as soon as ready returns
      stim_q = {8'h01, 8'h11, 8'h22};
      card_q = stim_q;
      cmd_index = 6'd9; cmd_arg = 32'h0; cmd_resp_len = 3'd0; cmd_busy = 1'b0;
      cmd_valid = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!resp_valid && cyc < 3000);
      check_val("len0_bytes", resp_bytes, 40'h01);
      cmd_index = 6'd10; cmd_resp_len = 3'd7;
      stim_q = {8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      card_q = stim_q;
      @(negedge clk);
      check_val("held_ready", cmd_ready, 1);
      @(negedge clk);
      check_val("held_taken", cmd_ready, 0);
      cyc = 0;
      while (!resp_valid && cyc < 3000) begin @(negedge clk); cyc++; end
      check_val("len7_bytes", resp_bytes, 40'h4433221101);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);

      // Randomized commands
      for (int n = 0; n < 30; n++) begin
         stim_q = {};
         nff = $urandom_range(0, 9);
         repeat (nff) stim_q.push_back(8'hFF);
         stim_q.push_back(8'($urandom_range(0, 254)));
         repeat (4) stim_q.push_back(8'($urandom_range(0, 255)));
         nz = $urandom_range(0, 5);
         repeat (nz) stim_q.push_back(8'h00);
         stim_q.push_back(8'($urandom_range(1, 255)));
         run_cmd(6'($urandom_range(0, 63)), $urandom, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));
      end

      check_val("req_protocol", bad_req, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
